// File: rtl/nr14_interval_timer.sv
// nr14_interval_timer: prescaled down-counting interval timer with sticky irq; NR14_TIMER_OVERRUN_EN adds ovr/ovr_flag.
module nr14_interval_timer #(
  parameter int CW = 14,
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_period,
  input  logic [CW-1:0] period_in,
  input  logic          ld_pre,
  input  logic [PW-1:0] pre_in,
  input  logic          start,
  input  logic          stop,
  input  logic          oneshot,
  input  logic          irq_ack,
  output logic          irq,
  output logic          running,
  output logic [CW-1:0] count,
  output logic          zero
`ifdef NR14_TIMER_OVERRUN_EN
  ,
  output logic [3:0]    ovr,
  output logic          ovr_flag
`endif
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] period_q, period_d, count_q, count_d;
  logic [PW-1:0] pre_q, pre_d, psc_q, psc_d;
  logic irq_q, irq_d, os_q, os_d, expiry;
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    psc_d    = psc_q;
    os_d     = os_q;
    expiry   = 1'b0;
    period_d = ld_period ? period_in : period_q;
    pre_d    = ld_pre ? pre_in : pre_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        psc_d   = pre_q;
        count_d = period_q;
        os_d    = oneshot;
      end
    end else if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      psc_d   = pre_q;
      count_d = period_q;
      os_d    = oneshot;
    end else if (psc_q != '0) begin
      psc_d = psc_q - PW'(1);
    end else begin
      psc_d = pre_q;
      if (!zero) begin
        count_d = count_q - CW'(1);
      end else begin
        expiry  = 1'b1;
        count_d = period_q;
        state_d = os_q ? IDLE : RUN;
      end
    end
    // set wins over a simultaneous acknowledge
    irq_d = expiry | (irq_q & ~irq_ack);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      period_q <= '0;
      pre_q    <= '0;
      psc_q    <= '0;
      count_q  <= '0;
      irq_q    <= 1'b0;
      os_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      pre_q    <= pre_d;
      psc_q    <= psc_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
      os_q     <= os_d;
    end
  end
  assign zero    = count_q == '0;
  assign count   = count_q;
  assign running = state_q == RUN;
  assign irq     = irq_q;
`ifdef NR14_TIMER_OVERRUN_EN
  logic [3:0] ovr_q, ovr_d;
  always_comb ovr_d = irq_ack ? 4'd0 : (expiry && irq_q && ovr_q != 4'hf) ? ovr_q + 4'd1 : ovr_q;
  always_ff @(posedge clk) ovr_q <= reset ? 4'd0 : ovr_d;
  assign ovr      = ovr_q;
  assign ovr_flag = ovr_q != 4'd0;
`endif
endmodule

// File: doc/nr14_interval_timer.md
Name: nr14_interval_timer

Overview:
- Sequencer for the 14-bit all-zero detector: a programmable down-counting interval timer with an 8-bit prescaler.
- The main counter's 14 bits feed the zero detect; the detect result drives reload, the interrupt request and the one-shot stop.
- Sits on the TOM register bus. Host writes the period and prescale, issues start/stop, and acknowledges interrupts.

Parameters:
- CW, 14, main counter width (matches the zero-detector input count)
- PW, 8, prescaler width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ld_period  in  1  strobe: load period register from period_in
- period_in  in  CW  main reload value
- ld_pre  in  1  strobe: load prescale register from pre_in
- pre_in  in  PW  prescaler reload value
- start  in  1  strobe: begin or restart counting
- stop  in  1  strobe: halt counting
- oneshot  in  1  mode, sampled at start: 1 = stop after the first expiry
- irq_ack  in  1  clears irq
- irq  out  1  sticky expiry interrupt request
- running  out  1  timer in RUN state
- count  out  CW  current main counter value
- zero  out  1  combinational: count == 0 (14-input NOR)

Behaviour:
- Reset: period=0, pre=0, prescaler=0, count=0, state IDLE, irq=0, running=0, latched oneshot=0. zero=1 after reset.
- Register loads: ld_period and ld_pre update their registers next edge in any state. No effect on the live counters until the next reload.
- States: IDLE, RUN.
- IDLE:
  - start -> RUN next edge. prescaler<=pre, count<=period, latch oneshot. running=1 from that edge.
  - stop in IDLE is ignored.
- RUN, each edge, in priority order:
  1. stop: -> IDLE. Counters freeze at their current values. irq unchanged.
  2. start: restart. prescaler<=pre, count<=period, re-latch oneshot. No expiry is evaluated this cycle.
  3. prescaler != 0: prescaler decrements.
  4. prescaler == 0 (tick): prescaler<=pre, then:
     - zero=0: count decrements.
     - zero=1 (expiry): count<=period, irq<=1. If the latched oneshot=1, -> IDLE with count=period.
- Stop wins if stop and start arrive in the same cycle.
- Period between expiries: (pre+1)*(period+1) clocks.
- period=0: expiry on every tick. pre=0: tick on every clock. Both 0: expiry every clock.
- irq:
  - Set by expiry, cleared by irq_ack.
  - Expiry and irq_ack in the same cycle: irq stays 1 (set wins).
  - irq_ack with irq=0: no effect.
- zero is combinational from the count register. count and running are registered.
- reset asserted mid-count returns everything to its reset values on the next edge, regardless of other inputs.

Optional Feature:
- Macro: NR14_TIMER_OVERRUN_EN
- Enabled:
  - Adds output ovr[3:0]: saturating count of expiries that occur while irq is already 1 with no irq_ack that cycle. Saturates at 15.
  - Cleared to 0 by irq_ack and by reset.
  - Also adds output ovr_flag = (ovr != 0).
- Disabled: ovr and ovr_flag do not exist. Extra expiries while irq=1 are silently merged into the pending irq.

Test Plan:
- Reset, then load period=3, pre=0, start with oneshot=0 -> count sequence 3,2,1,0,3. irq rises on the edge where count reloads 0->3, i.e. 4 clocks after running rises. Repeats every 4 clocks.
- period=2, pre=4, start -> count changes every 5 clocks. First irq 15 clocks after start. running stays 1.
- oneshot=1, period=1, pre=0, start -> irq=1 and running=0 at 2 clocks after start. count=1 is held. No further irq after ack.
- Assert irq_ack in the exact cycle of the next expiry (period=0, pre=0) -> irq remains 1. A lone ack the following cycle, with the next expiry suppressed by stop, -> irq=0.
- Running with period=5: assert start and stop together -> IDLE, count frozen, running=0. Then ld_period=9 and start -> count=9 next edge.
- With NR14_TIMER_OVERRUN_EN: period=0, pre=0, no ack for 20 clocks -> ovr saturates at 15 and ovr_flag=1. One irq_ack -> ovr=0 next edge.
